// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester side and UART TX side of the shared
// transmitter arbiter, grouped into one bundle.
// With UART_TX_ARB_HOLD_TIMEOUT_EN defined the bundle also carries timeout_o.

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic [7:0]           tx_data_o;
  logic                 tx_valid_o;
  logic                 tx_busy_i;
  logic [15:0]          tx_count_o;
  logic                 idle_o;
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
  logic                 timeout_o;

  // arbiter view
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_busy_i,
    output req_ready_o, grant_o, tx_data_o, tx_valid_o, tx_count_o, idle_o, timeout_o
  );

  // requester / UART view
  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_busy_i,
    input  req_ready_o, grant_o, tx_data_o, tx_valid_o, tx_count_o, idle_o, timeout_o
  );
`else
  // arbiter view
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_busy_i,
    output req_ready_o, grant_o, tx_data_o, tx_valid_o, tx_count_o, idle_o
  );

  // requester / UART view
  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_busy_i,
    input  req_ready_o, grant_o, tx_data_o, tx_valid_o, tx_count_o, idle_o
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX byte port among NUM_REQ requesters.
// Round-robin grant; a granted requester keeps the line until it sends a byte
// flagged last, so packets never interleave. Each byte is sequenced as
// issue -> busy rises -> busy falls.
// Optional build macro: UART_TX_ARB_HOLD_TIMEOUT_EN releases a lock whose owner
// stays silent for HOLD_TIMEOUT cycles and pulses timeout_o.

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PTR_W        = $clog2(NUM_REQ),
  parameter int HOLD_TIMEOUT = 65535
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  // Reject parameter sets the index arithmetic cannot cover.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
  end
  if (HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > 65535) begin : g_bad_hold_timeout
    $error("uart_tx_arbiter: HOLD_TIMEOUT must be within 1..65535");
  end

  state_t           state_r;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] owner_r;
  logic             last_r;
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
  logic [15:0]      hold_cnt_r;
`endif

  logic             win_found_s;
  logic [PTR_W-1:0] win_idx_s;
  logic [PTR_W-1:0] sel_idx_s;
  logic [PTR_W-1:0] nxt_ptr_s;
  logic [7:0]       sel_data_s;
  logic             sel_last_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = {NUM_REQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int  j;
    logic hit;
    j           = 0;
    hit         = 1'b0;
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      j           = (int'(rr_ptr_r) + i) % NUM_REQ;
      hit         = bus.req_valid_i[PTR_W'(j)] && !win_found_s;
      win_idx_s   = hit ? PTR_W'(j) : win_idx_s;
      win_found_s = win_found_s | hit;
    end
  end

  // Byte/last mux: HOLD only listens to the owner, ARB to the search winner.
  always_comb begin
    sel_idx_s  = (state_r == ST_HOLD) ? owner_r : win_idx_s;
    sel_data_s = bus.req_data_i[{sel_idx_s, 3'b000} +: 8];
    sel_last_s = bus.req_last_i[sel_idx_s];
    nxt_ptr_s  = (owner_r == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : owner_r + 1'b1;
  end

  // Arbitration / byte sequencing FSM; every output is registered here.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r         <= ST_ARB;
      rr_ptr_r        <= {PTR_W{1'b0}};
      owner_r         <= {PTR_W{1'b0}};
      last_r          <= 1'b0;
      bus.req_ready_o <= {NUM_REQ{1'b0}};
      bus.grant_o     <= {NUM_REQ{1'b0}};
      bus.tx_data_o   <= 8'h00;
      bus.tx_valid_o  <= 1'b0;
      bus.tx_count_o  <= 16'h0000;
      bus.idle_o      <= 1'b1;
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
      hold_cnt_r      <= 16'h0000;
      bus.timeout_o   <= 1'b0;
`endif
    end else begin
      bus.req_ready_o <= {NUM_REQ{1'b0}};
      bus.tx_valid_o  <= 1'b0;
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
      bus.timeout_o   <= 1'b0;
`endif
      case (state_r)
        ST_ARB: begin
          if (!bus.tx_busy_i && win_found_s) begin
            bus.req_ready_o <= onehot(win_idx_s);
            bus.tx_data_o   <= sel_data_s;
            last_r          <= sel_last_s;
            owner_r         <= win_idx_s;
            bus.grant_o     <= onehot(win_idx_s);
            bus.idle_o      <= 1'b0;
            state_r         <= ST_LOAD;
          end else begin
            state_r <= ST_ARB;
          end
        end
        ST_LOAD: begin
          bus.tx_valid_o <= 1'b1;
          bus.tx_count_o <= bus.tx_count_o + 16'd1;
          state_r        <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy_i) begin
            state_r <= ST_WAIT_DONE;
          end else begin
            state_r <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.tx_busy_i) begin
            state_r <= ST_WAIT_DONE;
          end else if (last_r) begin
            owner_r     <= {PTR_W{1'b0}};
            bus.grant_o <= {NUM_REQ{1'b0}};
            rr_ptr_r    <= nxt_ptr_s;
            bus.idle_o  <= 1'b1;
            state_r     <= ST_ARB;
          end else begin
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
            hold_cnt_r <= 16'h0000;
`endif
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.req_valid_i[owner_r]) begin
            bus.req_ready_o <= onehot(owner_r);
            bus.tx_data_o   <= sel_data_s;
            last_r          <= sel_last_s;
            state_r         <= ST_LOAD;
          end
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
          else if (hold_cnt_r == 16'(HOLD_TIMEOUT - 1)) begin
            // owner went silent mid-packet: drop the lock so others can run
            owner_r       <= {PTR_W{1'b0}};
            bus.grant_o   <= {NUM_REQ{1'b0}};
            rr_ptr_r      <= nxt_ptr_s;
            bus.idle_o    <= 1'b1;
            bus.timeout_o <= 1'b1;
            state_r       <= ST_ARB;
          end else begin
            hold_cnt_r <= hold_cnt_r + 16'd1;
          end
`else
          else begin
            state_r <= ST_HOLD;
          end
`endif
        end
        default: begin
          owner_r     <= {PTR_W{1'b0}};
          bus.grant_o <= {NUM_REQ{1'b0}};
          bus.idle_o  <= 1'b1;
          state_r     <= ST_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// Per-requester byte queues feed the requester ports, a small UART model
// answers tx_valid_o with a busy window, and every byte seen on the line is
// compared against the expected (owner, data) sequence pushed by each test.

module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [2:0] owner;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rstn;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .HOLD_TIMEOUT (16)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  int         n_checks;
  int         n_errors;
  exp_t       sb[$];
  logic [8:0] rq[4][$];
  int         exp_count;
  int         busy_dly;
  int         busy_len;
  logic       prev_valid;
  logic [3:0] prev_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < 4; k++) if (rq[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic send(input int k, input logic last, input logic [7:0] data);
    sb.push_back(exp_t'({3'(k), data}));
    rq[k].push_back({last, data});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(bus.idle_o && !bus.tx_busy_i && sb.size() == 0 && queues_empty()) && n < budget);
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.tx_valid_o && n < budget);
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready_o), 32'h0);
    check({tag, "_grant"}, 32'(bus.grant_o), 32'h0);
    check({tag, "_data"},  32'(bus.tx_data_o), 32'h00);
    check({tag, "_valid"}, 32'(bus.tx_valid_o), 32'h0);
    check({tag, "_count"}, 32'(bus.tx_count_o), 32'h0);
    check({tag, "_idle"},  32'(bus.idle_o), 32'h1);
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
    check({tag, "_timeout"}, 32'(bus.timeout_o), 32'h0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    exp_count = 0;
    sb.delete();
    for (int k = 0; k < 4; k++) rq[k].delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Requester model: retire a byte on its ready pulse, present the next one.
  initial begin
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic [8:0]  h;
    bus.req_valid_i = 4'h0;
    bus.req_data_i  = 32'h0;
    bus.req_last_i  = 4'h0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (rstn && bus.req_ready_o[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      v = 4'h0; d = 32'h0; l = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (rq[k].size() > 0) begin
          h          = rq[k][0];
          v[k]       = 1'b1;
          d[8*k +: 8] = h[7:0];
          l[k]       = h[8];
        end
      end
      bus.req_valid_i = v;
      bus.req_data_i  = d;
      bus.req_last_i  = l;
    end
  end

  // UART model: busy rises busy_dly cycles after the start pulse, lasts busy_len.
  initial begin
    bus.tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && bus.tx_valid_o) begin
        for (int i = 0; i < busy_dly && rstn; i++) @(negedge clk);
        if (rstn) bus.tx_busy_i = 1'b1;
        for (int i = 0; i < busy_len && rstn; i++) @(negedge clk);
        bus.tx_busy_i = 1'b0;
      end
    end
  end

  // Line monitor: ready ordering, T+1 latency, byte contents and count.
  initial begin
    exp_t e;
    prev_valid = 1'b0;
    prev_ready = 4'h0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_valid = 1'b0;
        prev_ready = 4'h0;
      end else begin
        if (bus.req_ready_o != 4'h0) begin
          check("ready_onehot", 32'($countones(bus.req_ready_o)), 32'd1);
          if (sb.size() > 0) check("ready_owner", 32'(bus.req_ready_o), 32'd1 << sb[0].owner);
          else check("ready_unexpected", 32'(bus.req_ready_o), 32'h0);
        end
        if (bus.tx_valid_o) begin
          check("valid_width", 32'(prev_valid), 32'h0);
          check("latency", 32'(prev_ready), 32'(bus.grant_o));
          if (sb.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            check("tx_data", 32'(bus.tx_data_o), 32'(e.data));
            check("grant", 32'(bus.grant_o), 32'd1 << e.owner);
          end
          exp_count = (exp_count + 1) & 16'hFFFF;
          check("tx_count", 32'(bus.tx_count_o), 32'(exp_count));
        end
        prev_valid = bus.tx_valid_o;
        prev_ready = bus.req_ready_o;
      end
    end
  end

  initial begin
    int n;
    n_checks  = 0;
    n_errors  = 0;
    exp_count = 0;
    busy_dly  = 0;
    busy_len  = 4;
    rstn      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;

    // single byte from requester 0
    send(0, 1'b1, 8'hA5);
    wait_idle("single_done", 40);
    check("single_idle", 32'(bus.idle_o), 32'h1);
    check("single_grant", 32'(bus.grant_o), 32'h0);
    check("single_count", 32'(bus.tx_count_o), 32'd1);

    // contention from rr_ptr=0, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) send(k, 1'b1, 8'(8'h10 + 8'(16 * r) + 8'(k)));
      wait_idle("contention_done", 120);
    end
    check("contention_count", 32'(bus.tx_count_o), 32'd8);

    // packet lock: req1 three bytes, req2 waiting; req0 arrives mid-packet
    send(1, 1'b0, 8'hB1);
    send(1, 1'b0, 8'hB2);
    send(1, 1'b1, 8'hB3);
    send(2, 1'b1, 8'hC2);
    repeat (3) @(negedge clk);
    #1;
    check("lock_grant", 32'(bus.grant_o), 32'h2);
    send(0, 1'b1, 8'hD0);
    wait_idle("lock_done", 200);

    // busy rises three cycles after the start pulse
    busy_dly = 3;
    send(2, 1'b1, 8'h5A);
    wait_valid("busy_valid_seen", 30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("busy_valid_once", 32'(bus.tx_valid_o), 32'h0);
      check("busy_grant_held", 32'(bus.grant_o), 32'h4);
    end
    wait_idle("busy_done", 60);
    busy_dly = 0;

    // reset during WAIT_DONE of a non-last byte
    send(1, 1'b0, 8'h3C);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!bus.tx_busy_i && n < 40);
    check("rst_busy_seen", 32'(n < 40), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    exp_count = 0;
    sb.delete();
    for (int k = 0; k < 4; k++) rq[k].delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    send(3, 1'b1, 8'hE3);
    wait_idle("rst_after_done", 40);
    check("rst_after_count", 32'(bus.tx_count_o), 32'd1);

`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
    // owner 0 goes silent after a non-last byte while req2 waits
    send(0, 1'b0, 8'h71);
    send(2, 1'b1, 8'h72);
    wait_valid("to_valid_seen", 30);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.timeout_o && n < 100);
    check("to_latency", 32'(n), 32'(busy_len + 17));
    check("to_grant", 32'(bus.grant_o), 32'h0);
    @(negedge clk); #1;
    check("to_pulse", 32'(bus.timeout_o), 32'h0);
    wait_idle("to_done", 60);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface (data/valid in, busy out) among NUM_REQ independent requesters. Examples: core MMIO, debug monitor, DMA log.
- Round-robin arbitration with packet locking. A granted requester keeps the transmitter until it sends a byte flagged last, so packets from different requesters never interleave on the line.
- Sits between requester logic and the UART TX block. Sequences each byte: issue, wait for busy to rise, wait for busy to fall.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer and owner index.
- HOLD_TIMEOUT, 65535, idle cycles allowed while a lock is held (used only with the optional feature).

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  asynchronous active-low reset.
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_data_i  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  input  NUM_REQ  byte is the last of its packet; releases the lock.
- req_ready_o  output  NUM_REQ  one-cycle accept pulse, at most one bit set.
- grant_o  output  NUM_REQ  one-hot current owner; all zero when no owner.
- tx_data_o  output  8  byte to the UART TX.
- tx_valid_o  output  1  one-cycle start pulse to the UART TX.
- tx_busy_i  input  1  UART TX busy.
- tx_count_o  output  16  count of bytes issued; wraps 0xFFFF->0x0000.
- idle_o  output  1  high in ARB state with no owner.

Behaviour:
- Reset (asynchronous, rstn_i=0):
  - state=ARB, rr_ptr=0, owner cleared.
  - Outputs: req_ready_o=0, grant_o=0, tx_data_o=8'h00, tx_valid_o=0, tx_count_o=0, idle_o=1.
  - Reset mid-byte abandons the byte. The UART is reset from the same source.
- States: ARB, LOAD, WAIT_BUSY, WAIT_DONE, HOLD.
- ARB:
  - Acts only when tx_busy_i=0 and some req_valid_i is set.
  - Winner: first set bit searching upward from rr_ptr, modulo NUM_REQ.
  - Same cycle: req_ready_o[winner]=1. Register data into tx_data_o, latch last flag, set owner=winner and grant_o one-hot. Go to LOAD.
- LOAD: tx_valid_o=1 for exactly this one cycle; tx_count_o increments. Go to WAIT_BUSY.
- Latency: byte accepted at cycle T, tx_valid_o high at T+1.
- WAIT_BUSY: wait for tx_busy_i=1, then go to WAIT_DONE. tx_valid_o is never re-asserted.
- WAIT_DONE: wait for tx_busy_i=0.
  - Latched last=1: clear owner and grant_o, set rr_ptr=owner+1 (mod NUM_REQ), go to ARB.
  - Latched last=0: go to HOLD; grant_o is kept.
- HOLD:
  - Only req_valid_i[owner] is considered; other requesters stall even if valid.
  - When req_valid_i[owner]=1: ready pulse to owner, capture byte and last flag, go to LOAD.
- Simultaneous requests: exactly one ready per cycle. Losers keep valid asserted and keep their data stable.
- req_valid_i for a non-owner during HOLD is ignored and no error is raised.
- tx_data_o holds its value between bytes.
- idle_o = (state==ARB).
- req_ready_o must never pulse outside ARB/HOLD acceptance.

Optional Feature:
- Macro: UART_TX_ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A 16-bit counter counts cycles in HOLD and resets on entry.
  - If it reaches HOLD_TIMEOUT without owner valid: force release (grant_o=0, rr_ptr=owner+1, go to ARB).
  - Pulse added output port timeout_o (1 bit, reset 0) for one cycle.
- Not defined: no counter, no timeout_o port; HOLD waits indefinitely.

Test Plan:
- Single byte: req 0 presents 8'hA5 with last=1.
  -> ready[0] at T, tx_valid_o=1 with tx_data_o=8'hA5 at T+1, grant_o=4'b0001 until busy falls, then idle_o=1 and tx_count_o=1.
- Contention: req 0..3 all valid with last=1, each with a distinct byte, rr_ptr=0.
  -> grant order 0,1,2,3 and bytes on the line in that order; re-arming all four gives order 0,1,2,3 again.
- Packet lock: req 1 sends 3 bytes (last on the third) while req 2 is valid throughout.
  -> all three req 1 bytes go out back-to-back before any ready[2]; rr_ptr=2 afterwards.
- Busy handshake: UART model delays busy rise by 3 cycles after valid.
  -> controller stays in WAIT_BUSY and tx_valid_o stays high for exactly 1 cycle.
- Reset mid-packet: assert rstn_i=0 during WAIT_DONE of a non-last byte.
  -> all outputs return to reset values immediately; after release, req 3 wins first since rr_ptr=0 and req 0..2 are idle.
- With UART_TX_ARB_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=16: owner stops after a non-last byte.
  -> timeout_o pulses 16 cycles after HOLD entry, grant_o=0, and a waiting requester is granted next.
